// File: rtl/flop_mux_primitives_pkg.sv
// flop_mux_primitives_pkg: shared datapath width, reset constant and mux select encodings.
package flop_mux_primitives_pkg;
    localparam int WORD_WIDTH = 16;
    localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;
    // Datapath-level meanings of the mux selects; the primitives themselves stay generic.
    typedef enum logic [1:0] {
        PC_SEL_INC,
        PC_SEL_BRANCH,
        PC_SEL_JUMP,
        PC_SEL_ALU
    } pc_sel_e;
    typedef enum logic [1:0] {
        ALU_A_REG,
        ALU_A_PC,
        ALU_A_ZERO,
        ALU_A_MEM
    } alu_a_sel_e;
    typedef enum logic [1:0] {
        ALU_B_REG,
        ALU_B_IMM,
        ALU_B_TWO,
        ALU_B_MEM
    } alu_b_sel_e;
    typedef enum logic [1:0] {
        ADDR_SEL_PC,
        ADDR_SEL_ALU,
        ADDR_SEL_SP,
        ADDR_SEL_REG
    } addr_sel_e;
    typedef enum logic [2:0] {
        WD_SEL_ALU,
        WD_SEL_MEM,
        WD_SEL_PC,
        WD_SEL_IMM,
        WD_SEL_STATUS,
        WD_SEL_SHIFT,
        WD_SEL_ZERO,
        WD_SEL_IO
    } wd_sel_e;
endpackage

// File: rtl/flop_mux_primitives_if.sv
// flop_mux_primitives_if: register and mux data/select/result bundle.
interface flop_mux_primitives_if #(parameter int WIDTH = 16);
    logic             enable;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m4_d0, m4_d1, m4_d2, m4_d3;
    logic [1:0]       m4_sel;
    logic [WIDTH-1:0] m4_y;
    logic [WIDTH-1:0] m8_d0, m8_d1, m8_d2, m8_d3, m8_d4, m8_d5, m8_d6, m8_d7;
    logic [2:0]       m8_sel;
    logic [WIDTH-1:0] m8_y;
    modport master (
        output enable, d, m4_d0, m4_d1, m4_d2, m4_d3, m4_sel,
               m8_d0, m8_d1, m8_d2, m8_d3, m8_d4, m8_d5, m8_d6, m8_d7, m8_sel,
        input  q, m4_y, m8_y
    );
    modport slave (
        input  enable, d, m4_d0, m4_d1, m4_d2, m4_d3, m4_sel,
               m8_d0, m8_d1, m8_d2, m8_d3, m8_d4, m8_d5, m8_d6, m8_d7, m8_sel,
        output q, m4_y, m8_y
    );
endinterface

// File: rtl/flop_enable_reset.sv
// flop_enable_reset: enabled register with asynchronous active-low reset.
module flop_enable_reset #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clock or negedge reset)
        if (!reset) q <= RESET_VALUE;
        else if (enable) q <= d;
endmodule

// File: rtl/mux4.sv
// mux4: 4:1 combinational multiplexer.
module mux4 #(parameter int WIDTH = 16) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);
    always_comb y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
endmodule

// File: rtl/mux8.sv
// mux8: 8:1 multiplexer built from two mux4 halves and a final 2:1 on sel[2].
module mux8 #(parameter int WIDTH = 16) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] lo, hi;
    mux4 #(.WIDTH(WIDTH)) u_lo (.d0(d0), .d1(d1), .d2(d2), .d3(d3), .sel(sel[1:0]), .y(lo));
    mux4 #(.WIDTH(WIDTH)) u_hi (.d0(d4), .d1(d5), .d2(d6), .d3(d7), .sel(sel[1:0]), .y(hi));
    always_comb y = sel[2] ? hi : lo;
endmodule

// File: rtl/flop_mux_primitives.sv
// flop_mux_primitives: thin top placing one register, one mux4 and one mux8 side by side.
module flop_mux_primitives
    import flop_mux_primitives_pkg::*;
#(
    parameter int               WIDTH       = WORD_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = ZERO_WORD
) (
    input logic                  clock,
    input logic                  reset,
    flop_mux_primitives_if.slave bus
);
    flop_enable_reset #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_flop (
        .clock  (clock),
        .reset  (reset),
        .enable (bus.enable),
        .d      (bus.d),
        .q      (bus.q)
    );
    mux4 #(.WIDTH(WIDTH)) u_mux4 (
        .d0  (bus.m4_d0),
        .d1  (bus.m4_d1),
        .d2  (bus.m4_d2),
        .d3  (bus.m4_d3),
        .sel (bus.m4_sel),
        .y   (bus.m4_y)
    );
    mux8 #(.WIDTH(WIDTH)) u_mux8 (
        .d0  (bus.m8_d0),
        .d1  (bus.m8_d1),
        .d2  (bus.m8_d2),
        .d3  (bus.m8_d3),
        .d4  (bus.m8_d4),
        .d5  (bus.m8_d5),
        .d6  (bus.m8_d6),
        .d7  (bus.m8_d7),
        .sel (bus.m8_sel),
        .y   (bus.m8_y)
    );
endmodule

// File: tb/tb_flop_mux_primitives.sv
// tb_flop_mux_primitives: directed plus randomized check of register and muxes against a reference model.
module tb_flop_mux_primitives;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [15:0] m4v [4];
    logic [15:0] m8v [8];
    logic [15:0] exp_q = 16'hxxxx;
    logic cmp_on = 1'b0;
    int checks = 0;
    int errors = 0;

    flop_mux_primitives_if #(.WIDTH(16)) bus ();

    flop_mux_primitives #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    assign bus.m4_d0 = m4v[0];
    assign bus.m4_d1 = m4v[1];
    assign bus.m4_d2 = m4v[2];
    assign bus.m4_d3 = m4v[3];
    assign bus.m8_d0 = m8v[0];
    assign bus.m8_d1 = m8v[1];
    assign bus.m8_d2 = m8v[2];
    assign bus.m8_d3 = m8v[3];
    assign bus.m8_d4 = m8v[4];
    assign bus.m8_d5 = m8v[5];
    assign bus.m8_d6 = m8v[6];
    assign bus.m8_d7 = m8v[7];

    // Reference register: cleared whenever reset is low, otherwise takes d on enabled edges.
    always @(posedge clock or negedge reset) begin
        if (!reset) exp_q = 16'h0000;
        else if (bus.enable) exp_q = bus.d;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_on) begin
            check("model_q", bus.q, exp_q);
            check("model_m4", bus.m4_y, m4v[bus.m4_sel]);
            check("model_m8", bus.m8_y, m8v[bus.m8_sel]);
        end
    end

    task automatic edge_step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.d = 16'h0000;
        bus.m4_sel = 2'd0;
        bus.m8_sel = 3'd0;
        for (int i = 0; i < 4; i++) m4v[i] = 16'h0000;
        for (int i = 0; i < 8; i++) m8v[i] = 16'h0000;
        #2 reset = 1'b0;
        #1 cmp_on = 1'b1;
        check("por_reset", bus.q, 16'h0000);
        edge_step();
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.d = 16'hBEEF;
        edge_step();
        check("load_beef", bus.q, 16'hBEEF);
        #3 reset = 1'b0;
        #1 check("async_clear", bus.q, 16'h0000);
        bus.d = 16'h1234;
        repeat (3) edge_step();
        check("reset_hold", bus.q, 16'h0000);
        reset = 1'b1;
        bus.d = 16'h00A5;
        edge_step();
        check("load_a5", bus.q, 16'h00A5);
        bus.enable = 1'b0;
        bus.d = 16'hFFFF;
        repeat (2) edge_step();
        check("enable_hold", bus.q, 16'h00A5);
        bus.enable = 1'b1;
        bus.d = 16'h0001;
        edge_step();
        check("b2b_0001", bus.q, 16'h0001);
        bus.d = 16'h8000;
        edge_step();
        check("b2b_8000", bus.q, 16'h8000);
        bus.d = 16'h7FFF;
        edge_step();
        check("b2b_7fff", bus.q, 16'h7FFF);
        m4v[0] = 16'h1111;
        m4v[1] = 16'h2222;
        m4v[2] = 16'h3333;
        m4v[3] = 16'h4444;
        for (int s = 0; s < 4; s++) begin
            bus.m4_sel = 2'(s);
            #1 check("m4_sweep", bus.m4_y, 16'(16'h1111 * (s + 1)));
        end
        bus.m4_sel = 2'd2;
        m4v[2] = 16'hDEAD;
        #1 check("m4_comb", bus.m4_y, 16'hDEAD);
        for (int i = 0; i < 8; i++) m8v[i] = 16'(16'h0100 + i);
        for (int s = 0; s < 8; s++) begin
            bus.m8_sel = 3'(s);
            #1 check("m8_sweep", bus.m8_y, 16'(16'h0100 + s));
        end
        for (int s = 0; s < 8; s++) begin
            bus.m8_sel = 3'(s);
            for (int i = 0; i < 8; i++) m8v[i] = (i == s) ? 16'(16'h0100 + s) : 16'hFFFF;
            #1 check("m8_ones", bus.m8_y, 16'(16'h0100 + s));
            for (int i = 0; i < 8; i++) m8v[i] = (i == s) ? 16'(16'h0100 + s) : 16'h0000;
            #1 check("m8_zeros", bus.m8_y, 16'(16'h0100 + s));
        end
        edge_step();
        bus.d = 16'hCAFE;
        edge_step();
        check("mid_cafe", bus.q, 16'hCAFE);
        #5 reset = 1'b0;
        #1 check("mid_clear", bus.q, 16'h0000);
        #1 reset = 1'b1;
        bus.d = 16'h0042;
        edge_step();
        check("mid_0042", bus.q, 16'h0042);
        repeat (400) begin
            edge_step();
            reset = ($urandom_range(15) != 0);
            bus.enable = 1'($urandom);
            bus.d = 16'($urandom);
            bus.m4_sel = 2'($urandom);
            bus.m8_sel = 3'($urandom);
            for (int i = 0; i < 4; i++) m4v[i] = 16'($urandom);
            for (int i = 0; i < 8; i++) m8v[i] = 16'($urandom);
        end
        @(negedge clock);
        #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
